// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the instruction/data memory arbiter.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StAddr = 2'd1,
    StData = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    SizeByte = 2'd0,
    SizeHalf = 2'd1,
    SizeWord = 2'd2
  } size_e;

  typedef enum logic {
    OwnInst = 1'b0,
    OwnData = 1'b1
  } owner_e;

  // Everything latched onto the shared memory port at grant time.
  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mreq_t;

endpackage

// File: rtl/mem_arbiter_arb_pick.sv
// Priority and starvation decision: data wins unless inst has been passed over StarveLimit times.
module arb_pick
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned StarveLimit = 4,
  localparam int unsigned CntW = $clog2(StarveLimit + 1)
) (
  input  logic            inst_req_i,
  input  logic            data_req_i,
  input  logic [CntW-1:0] starve_cnt_i,
  output logic            grant_o,
  output owner_e          owner_o,
  output logic [CntW-1:0] starve_cnt_o
);

  logic starve_full;

  assign starve_full = (starve_cnt_i == CntW'(StarveLimit));

  always_comb begin
    grant_o      = inst_req_i | data_req_i;
    owner_o      = OwnInst;
    starve_cnt_o = starve_cnt_i;
    if (data_req_i && !(starve_full && inst_req_i)) begin
      owner_o = OwnData;
      if (inst_req_i && !starve_full) begin
        starve_cnt_o = starve_cnt_i + CntW'(1);
      end
    end else if (inst_req_i) begin
      owner_o      = OwnInst;
      starve_cnt_o = '0;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-master arbiter onto a single split address/data memory port, one transaction in flight.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned StarveLimit = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        inst_req_i,
  input  logic        inst_wr_i,
  input  logic [1:0]  inst_size_i,
  input  logic [3:0]  inst_wstrb_i,
  input  logic [31:0] inst_addr_i,
  input  logic [31:0] inst_wdata_i,
  output logic        inst_addr_ok_o,
  output logic        inst_data_ok_o,
  output logic [31:0] inst_rdata_o,
  input  logic        data_req_i,
  input  logic        data_wr_i,
  input  logic [1:0]  data_size_i,
  input  logic [3:0]  data_wstrb_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_addr_ok_o,
  output logic        data_data_ok_o,
  output logic [31:0] data_rdata_o,
  output logic        m_req_o,
  output logic        m_wr_o,
  output logic [1:0]  m_size_o,
  output logic [3:0]  m_wstrb_o,
  output logic [31:0] m_addr_o,
  output logic [31:0] m_wdata_o,
  input  logic        m_addr_ok_i,
  input  logic        m_data_ok_i,
  input  logic [31:0] m_rdata_i
);

  localparam int unsigned CntW = $clog2(StarveLimit + 1);

  state_e          state_q, state_d;
  owner_e          owner_q, owner_d;
  logic [CntW-1:0] starve_q, starve_d;
  logic            m_req_q, m_req_d;
  mreq_t           mreq_q, mreq_d;

  logic            pick_grant;
  owner_e          pick_owner;
  logic [CntW-1:0] pick_starve;
  mreq_t           inst_fields, data_fields;

  assign inst_fields = '{wr: inst_wr_i, size: inst_size_i, wstrb: inst_wstrb_i,
                         addr: inst_addr_i, wdata: inst_wdata_i};
  assign data_fields = '{wr: data_wr_i, size: data_size_i, wstrb: data_wstrb_i,
                         addr: data_addr_i, wdata: data_wdata_i};

  arb_pick #(
    .StarveLimit(StarveLimit)
  ) u_arb_pick (
    .inst_req_i  (inst_req_i),
    .data_req_i  (data_req_i),
    .starve_cnt_i(starve_q),
    .grant_o     (pick_grant),
    .owner_o     (pick_owner),
    .starve_cnt_o(pick_starve)
  );

  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    starve_d       = starve_q;
    m_req_d        = m_req_q;
    mreq_d         = mreq_q;
    inst_addr_ok_o = 1'b0;
    data_addr_ok_o = 1'b0;
    inst_data_ok_o = 1'b0;
    data_data_ok_o = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (pick_grant) begin
          owner_d  = pick_owner;
          starve_d = pick_starve;
          mreq_d   = (pick_owner == OwnData) ? data_fields : inst_fields;
          m_req_d  = 1'b1;
          state_d  = StAddr;
        end
      end
      StAddr: begin
        if (m_addr_ok_i) begin
          inst_addr_ok_o = (owner_q == OwnInst);
          data_addr_ok_o = (owner_q == OwnData);
          m_req_d        = 1'b0;
          state_d        = StData;
        end
      end
      StData: begin
        if (m_data_ok_i) begin
          inst_data_ok_o = (owner_q == OwnInst);
          data_data_ok_o = (owner_q == OwnData);
          state_d        = StIdle;
        end
      end
      default: begin
        m_req_d = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      owner_q  <= OwnInst;
      starve_q <= '0;
      m_req_q  <= 1'b0;
      mreq_q   <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      starve_q <= starve_d;
      m_req_q  <= m_req_d;
      mreq_q   <= mreq_d;
    end
  end

  assign m_req_o      = m_req_q;
  assign m_wr_o       = mreq_q.wr;
  assign m_size_o     = mreq_q.size;
  assign m_wstrb_o    = mreq_q.wstrb;
  assign m_addr_o     = mreq_q.addr;
  assign m_wdata_o    = mreq_q.wdata;
  assign inst_rdata_o = m_rdata_i;
  assign data_rdata_o = m_rdata_i;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4, is the number of consecutive data grants allowed while an instruction request is pending.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 inst_req, inst_wr  input  1 each  instruction-master request and write flag.
REQ-005 inst_size  input  2  access size: 0 = byte, 1 = half, 2 = word.
REQ-006 inst_wstrb  input  4  byte-write strobes.
REQ-007 inst_addr, inst_wdata  input  32 each  instruction-master address and write data.
REQ-008 inst_addr_ok, inst_data_ok  output  1 each  instruction-master address accepted; data returned.
REQ-009 inst_rdata  output  32  instruction-master read data.
REQ-010 data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata  input  1/1/2/4/32/32  data-master request, same meaning as the inst_* inputs.
REQ-011 data_addr_ok, data_data_ok  output  1 each; data_rdata  output  32  data-master response.
REQ-012 m_req, m_wr  output  1 each; m_size  output  2; m_wstrb  output  4; m_addr, m_wdata  output  32 each  shared memory port, all registered.
REQ-013 m_addr_ok, m_data_ok  input  1 each; m_rdata  input  32  shared memory port response.

Function
REQ-014 The block SHALL implement a three-state FSM: IDLE, ADDR, DATA.
REQ-015 IDLE, any request pending: grant one master, latch its wr/size/wstrb/addr/wdata into the m_* registers, record the owner, and go to ADDR. Otherwise stay in IDLE.
REQ-016 Arbitration: data wins over inst unless starve_cnt == STARVE_LIMIT and inst_req is high; in that case inst wins.
REQ-017 starve_cnt: increments (saturating at STARVE_LIMIT) on each data grant while inst_req is high; clears on any inst grant; width is clog2(STARVE_LIMIT+1).
REQ-018 ADDR: m_req = 1. On m_addr_ok, pulse the owner's *_addr_ok for that same cycle, deassert m_req in the next cycle, and go to DATA.
REQ-019 DATA: m_req = 0. On m_data_ok, pulse the owner's *_data_ok for that same cycle, drive the owner's *_rdata = m_rdata, and go to IDLE.
REQ-020 Latency: request in IDLE at cycle N gives m_req = 1 at N+1. There is one IDLE cycle between transactions and only one transaction outstanding at a time.
REQ-021 The non-owner's addr_ok and data_ok SHALL be 0. Both rdata outputs SHALL be a combinational copy of m_rdata.
REQ-022 m_data_ok is ignored in IDLE and ADDR, and m_addr_ok is ignored in IDLE and DATA.
REQ-023 Masters hold req until addr_ok. The latched copy makes m_* immune to a request that is withdrawn or changed after the grant.
REQ-024 When both requests arrive in the same IDLE cycle, the loser stays pending and is granted in the next IDLE cycle if it is still requested and wins under REQ-016.

Reset
REQ-025 On rst low, asynchronously: state = IDLE; starve_cnt = 0; owner = inst; m_req, m_wr, m_size, m_wstrb, m_addr, m_wdata = 0; all addr_ok and data_ok = 0.
REQ-026 A reset during ADDR or DATA abandons the transaction. A late m_data_ok after reset release is ignored per REQ-022.

Structure
REQ-027 A shared package holds the FSM state encoding (IDLE = 0, ADDR = 1, DATA = 2), the size encodings, and the owner encoding (OWN_INST = 0, OWN_DATA = 1).
REQ-028 One sub-module, arb_pick, holds the combinational priority and starvation decision. Everything else stays in mem_arbiter.

Verification
REQ-029 Single inst read of 0xBFC00000 with m_addr_ok at N+1 and m_data_ok at N+3 (rdata 0x3C1D0000) -> inst_addr_ok at N+1, inst_data_ok with inst_rdata 0x3C1D0000 at N+3, data_* outputs stay 0.
REQ-030 inst_req and data_req both rise in the same cycle, data being a word write of 0x12345678 to 0x80001000 with wstrb 0xF -> data transaction first with exact m_* values, inst granted in the following IDLE.
REQ-031 Starvation, STARVE_LIMIT = 4: data_req and inst_req held high continuously -> 4 data grants, then 1 inst grant, with starve_cnt back to 0.
REQ-032 Slave stalls m_addr_ok for 5 cycles while the master changes its addr -> m_req stays high throughout, and m_addr keeps the originally latched value.
REQ-033 rst pulsed low during DATA, then m_data_ok arrives after release -> all outputs 0, state IDLE, no data_ok pulse to either master.
REQ-034 Spurious m_data_ok in IDLE and m_addr_ok in DATA -> no response pulses and no state change.
